// File: rtl/line_clear_sequencer.sv
// rtl/line_clear_sequencer.sv - scans, flashes and collapses full board rows; FLASH phase enabled by LINE_CLEAR_FLASH_EN
module line_clear_sequencer #(
    parameter int ROWS        = 20,
    parameter int COLS        = 12,
    parameter int FLASH_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] board_in,
    input  logic                 tick,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [ROWS*COLS-1:0] flash,
    output logic [4:0]           lines,
    output logic [5:0]           score_inc
);

    localparam int N  = ROWS * COLS;
    localparam int PW = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLASH,
        ST_COLLAPSE,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    board_q, board_d;
    logic [ROWS-1:0] full_q, full_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic [PW-1:0]   wp_q, wp_d;
    logic [4:0]      lines_q, lines_d;
    logic [5:0]      score_q, score_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [COLS-1:0] rd_row;
    logic            rd_full;
    logic            wr_en;
    logic [COLS-1:0] wr_row;

`ifdef LINE_CLEAR_FLASH_EN
    localparam int TW = $clog2(FLASH_TICKS + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [N-1:0]  flash_q, flash_d;
`else
    logic unused_flash_cfg;
    assign unused_flash_cfg = tick | (FLASH_TICKS == 0);
`endif

    function automatic logic [5:0] score_of(input logic [4:0] l);
        case (l)
            5'd0:    score_of = 6'd0;
            5'd1:    score_of = 6'd1;
            5'd2:    score_of = 6'd3;
            5'd3:    score_of = 6'd5;
            5'd4:    score_of = 6'd8;
            default: score_of = {l, 1'b0};
        endcase
    endfunction

    // rp doubles as the scan row and the collapse read row
    always_comb begin
        rd_row  = '0;
        rd_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (rp_q == PW'(r)) begin
                rd_row  = board_q[r*COLS +: COLS];
                rd_full = full_q[r];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        full_d  = full_q;
        rp_d    = rp_q;
        wp_d    = wp_q;
        lines_d = lines_q;
        score_d = score_q;
        wr_en   = 1'b0;
        wr_row  = '0;
`ifdef LINE_CLEAR_FLASH_EN
        tcnt_d  = tcnt_q;
        flash_d = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    board_d = board_in;
                    full_d  = '0;
                    lines_d = '0;
                    rp_d    = PW'(ROWS - 1);
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (&rd_row) begin
                    full_d  = full_q | (ROWS'(1) << rp_q);
                    lines_d = lines_q + 5'd1;
                end
                if (rp_q == '0) begin
                    rp_d = PW'(ROWS - 1);
                    wp_d = PW'(ROWS - 1);
                    if (lines_d == '0) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef LINE_CLEAR_FLASH_EN
                        tcnt_d  = '0;
                        state_d = ST_FLASH;
`else
                        state_d = ST_COLLAPSE;
`endif
                    end
                end else begin
                    rp_d = rp_q - PW'(1);
                end
            end
`ifdef LINE_CLEAR_FLASH_EN
            ST_FLASH: begin
                if (tick) begin
                    if (tcnt_q == TW'(FLASH_TICKS - 1)) begin
                        tcnt_d  = '0;
                        state_d = ST_COLLAPSE;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
`endif
            ST_COLLAPSE: begin
                // rp decrements past 0 into the out-of-range sentinel region
                if (rp_q < PW'(ROWS) && rd_full) begin
                    rp_d = rp_q - PW'(1);
                end else begin
                    wr_en  = 1'b1;
                    wr_row = (rp_q < PW'(ROWS)) ? rd_row : '0;
                    if (rp_q < PW'(ROWS)) rp_d = rp_q - PW'(1);
                    wp_d = wp_q - PW'(1);
                    if (wp_q == '0) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int r = 0; r < ROWS; r++) begin
            if (wr_en && wp_q == PW'(r)) board_d[r*COLS +: COLS] = wr_row;
        end

        if (state_d == ST_DONE) score_d = score_of(lines_d);

`ifdef LINE_CLEAR_FLASH_EN
        if (state_d == ST_FLASH) begin
            for (int r = 0; r < ROWS; r++) flash_d[r*COLS +: COLS] = {COLS{full_d[r]}};
        end
`endif
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            board_q <= '0;
            full_q  <= '0;
            rp_q    <= '0;
            wp_q    <= '0;
            lines_q <= '0;
            score_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LINE_CLEAR_FLASH_EN
            tcnt_q  <= '0;
            flash_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            full_q  <= full_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            lines_q <= lines_d;
            score_q <= score_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef LINE_CLEAR_FLASH_EN
            tcnt_q  <= tcnt_d;
            flash_q <= flash_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign board_out = board_q;
    assign lines     = lines_q;
    assign score_inc = score_q;
`ifdef LINE_CLEAR_FLASH_EN
    assign flash     = flash_q;
`else
    assign flash     = '0;
`endif

endmodule

// File: tb/tb_line_clear_sequencer.sv
// tb/tb_line_clear_sequencer.sv - directed and random line-clear runs against a row-queue reference model
module tb_line_clear_sequencer;

    localparam int ROWS = 20;
    localparam int COLS = 12;
    localparam int FT   = 4;
    localparam int N    = ROWS * COLS;
`ifdef LINE_CLEAR_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] board_in;
    logic         tick;
    logic         busy;
    logic         done;
    logic [N-1:0] board_out;
    logic [N-1:0] flash;
    logic [4:0]   lines;
    logic [5:0]   score_inc;

    int checks = 0;
    int errors = 0;

    line_clear_sequencer #(.ROWS(ROWS), .COLS(COLS), .FLASH_TICKS(FT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .board_in  (board_in),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .board_out (board_out),
        .flash     (flash),
        .lines     (lines),
        .score_inc (score_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int score_of(input int l);
        int tbl[5] = '{0, 1, 3, 5, 8};
        return (l < 5) ? tbl[l] : 2 * l;
    endfunction

    // Drop full rows, stack the survivors from the bottom in original order
    task automatic model(input logic [N-1:0] b, output logic [N-1:0] ob, output int l,
                         output logic [N-1:0] fm);
        logic [COLS-1:0] kept[$];
        logic [COLS-1:0] row;
        ob = '0;
        fm = '0;
        l  = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = b[r*COLS +: COLS];
            if (&row) begin
                l++;
                fm[r*COLS +: COLS] = '1;
            end else begin
                kept.push_back(row);
            end
        end
        for (int i = 0; i < kept.size(); i++) ob[(ROWS-1-i)*COLS +: COLS] = kept[i];
    endtask

    task automatic run_case(input logic [N-1:0] b, input bit mid, input string name);
        logic [N-1:0] eb, em;
        int el, n, tcnt, t_edge, done_edge;
        bit reached;
        model(b, eb, el, em);
        @(negedge clk);
        start    = 1'b1;
        board_in = b;
        tick     = 1'b0;
        @(posedge clk);
        n = 0; tcnt = 0; t_edge = -1; reached = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (el == 0)        done_edge = ROWS;
            else if (!FLASH_EN) done_edge = 2 * ROWS + el;
            else if (t_edge >= 0) done_edge = t_edge + ROWS + el;
            else                done_edge = 1 << 30;
            chk({name, "/busy"}, N'(busy), N'(1));
            chk({name, "/done"}, N'(done), N'(n == done_edge));
            chk({name, "/flash"}, flash,
                (FLASH_EN && el > 0 && n >= ROWS && (t_edge < 0 || n < t_edge)) ? em : '0);
            if (n == done_edge) begin
                chk({name, "/lines"}, N'(lines), N'(el));
                chk({name, "/score"}, N'(score_inc), N'(score_of(el)));
                chk({name, "/board"}, board_out, eb);
                reached = 1'b1;
                break;
            end
            start    = mid && (n == ROWS);
            board_in = ~b;
            tick     = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            n++;
            if (n > ROWS && tick && t_edge < 0) begin
                tcnt++;
                if (tcnt == FT) t_edge = n;
            end
        end
        chk({name, "/reached_done"}, N'(reached), N'(1));
        start = 1'b0;
        tick  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "/done_fall"}, N'(done), N'(0));
        chk({name, "/busy_fall"}, N'(busy), N'(0));
        chk({name, "/board_hold"}, board_out, eb);
        chk({name, "/lines_hold"}, N'(lines), N'(el));
        chk({name, "/score_hold"}, N'(score_inc), N'(score_of(el)));
    endtask

    initial begin
        logic [N-1:0] b;
        int rst_edge;
        rst = 1'b1; start = 1'b0; tick = 1'b0; board_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/busy", N'(busy), N'(0));
        chk("rst/done", N'(done), N'(0));
        chk("rst/board", board_out, '0);
        chk("rst/flash", flash, '0);
        chk("rst/lines", N'(lines), N'(0));
        chk("rst/score", N'(score_inc), N'(0));
        rst = 1'b0;

        run_case('0, 1'b0, "empty");

        b = '0;
        b[19*COLS +: COLS] = '1;
        b[18*COLS +: COLS] = 12'h001;
        run_case(b, 1'b1, "one_line");

        b = '0;
        for (int r = 16; r < 20; r++) b[r*COLS +: COLS] = '1;
        b[15*COLS +: COLS] = 12'hF0F;
        run_case(b, 1'b0, "four_lines");

        b = '0;
        b[10*COLS +: COLS] = '1;
        b[19*COLS +: COLS] = '1;
        b[9*COLS +: COLS]  = 12'hABC;
        b[11*COLS +: COLS] = 12'h123;
        b[18*COLS +: COLS] = 12'h456;
        run_case(b, 1'b0, "split_lines");

        run_case('1, 1'b0, "full_board");

        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < ROWS; r++)
                b[r*COLS +: COLS] = ($urandom_range(0, 2) == 0) ? '1 : COLS'($urandom);
            run_case(b, k == 2, "random");
        end

        // reset during COLLAPSE, with tick held so FLASH ends after FT cycles
        b = '0;
        b[19*COLS +: COLS] = '1;
        b[18*COLS +: COLS] = 12'h001;
        rst_edge = ROWS + 3 + (FLASH_EN ? FT : 0);
        @(negedge clk);
        start = 1'b1; board_in = b; tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (rst_edge - 2) @(posedge clk);
        @(negedge clk);
        chk("midrst/busy_before", N'(busy), N'(1));
        chk("midrst/done_before", N'(done), N'(0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst/busy", N'(busy), N'(0));
        chk("midrst/done", N'(done), N'(0));
        chk("midrst/board", board_out, '0);
        chk("midrst/flash", flash, '0);
        chk("midrst/lines", N'(lines), N'(0));
        chk("midrst/score", N'(score_inc), N'(0));
        rst = 1'b0;
        tick = 1'b0;
        run_case(b, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
